matrix_arb_lock: RTL and testbench

- Next-generation matrix (least-recently-served) arbiter for switch output ports.
- Adds a valid/ready handshake: priority only updates when a grant is actually accepted downstream.
- Adds packet locking for wormhole switching: a winner keeps the output until its tail flit transfers.
- Stores only the upper triangle of the priority matrix.
- Provides one-hot and binary grants plus a grant-valid flag.

---
 rtl/noc_arb_pkg.sv | 33 +++
 rtl/matrix_arb_prio.sv | 60 ++++++
 rtl/matrix_arb_lock.sv | 114 +++++++++++
 tb/tb_matrix_arb_lock.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the matrix arbiter family.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: state_e (ST_IDLE/ST_LOCKED), tri_idx (pair -> flat upper-triangle bit),
//           onehot2bin (one-hot of up to 16 bits -> 4-bit index).
package noc_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Flat bit index of pair (i,j) in a row-major upper triangle of an n x n
  // matrix (diagonal excluded). Argument order does not matter.
  function automatic int tri_idx(input int i, input int j, input int n);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // OR-reduction encoder; an all-zero input yields index 0.
  function automatic logic [3:0] onehot2bin(input logic [15:0] oh);
    logic [3:0] b;
    b = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (oh[k]) b = b | 4'(k);
    end
    return b;
  endfunction

endpackage

// File: rtl/matrix_arb_prio.sv
// Triangular least-recently-served priority matrix with combinational grant.
// Latency: grant is combinational from req_i; matrix update lands on the next edge.
// Backpressure: none internally; the caller strobes upd_i only on an accepted transfer.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i requests;
//        upd_i/upd_idx_i demote the given winner to lowest priority; grant_oh_o one-hot grant.
module matrix_arb_prio
  import noc_arb_pkg::*;
#(
  parameter int IN_N = 5,
  localparam int IDX_W = $clog2(IN_N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IN_N-1:0]  req_i,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  output logic [IN_N-1:0]  grant_oh_o
);

  localparam int PW = IN_N * (IN_N - 1) / 2;

  // p_q[tri_idx(i,j)] = 1 means i beats j for i<j; the lower triangle is implied.
  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  always_comb begin
    logic beaten;
    grant_oh_o = '0;
    beaten     = 1'b0;
    for (int g = 0; g < IN_N; g++) begin
      beaten = 1'b0;
      for (int k = 0; k < IN_N; k++) begin
        if (k != g && req_i[k]) begin
          if (k < g) beaten = beaten | p_q[tri_idx(k, g, IN_N)];
          else       beaten = beaten | ~p_q[tri_idx(g, k, IN_N)];
        end
      end
      grant_oh_o[g] = req_i[g] & ~beaten;
    end
  end

  // The winner loses every pair it takes part in; unrelated pairs keep their order.
  always_comb begin
    int w;
    p_d = p_q;
    w   = int'(upd_idx_i);
    if (upd_i) begin
      for (int j = 0; j < IN_N; j++) begin
        if (j > w)      p_d[tri_idx(w, j, IN_N)] = 1'b0;
        else if (j < w) p_d[tri_idx(j, w, IN_N)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) p_q <= '1;
    else         p_q <= p_d;
  end

endmodule

// File: rtl/matrix_arb_lock.sv
// Matrix (least-recently-served) output-port arbiter with optional wormhole packet lock.
// Latency: zero-cycle combinational grant; priority/lock state updates on the transfer edge.
// Backpressure: priority and lock only advance when grant_valid_o & ready_i.
// Ports: clk_i, rst_ni (async active-low); req_i, last_i (tail marker), ready_i;
//        grant_oh_o, grant_o, grant_valid_o, locked_o.
// Build option: define MATRIX_ARB_LOCK_EN to hold the output until the tail flit;
//               without it every transfer counts as a tail and locked_o is 0.
module matrix_arb_lock
  import noc_arb_pkg::*;
#(
  parameter int IN_N = 5,
  localparam int IDX_W = $clog2(IN_N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IN_N-1:0]  req_i,
  input  logic [IN_N-1:0]  last_i,
  input  logic             ready_i,
  output logic [IN_N-1:0]  grant_oh_o,
  output logic [IDX_W-1:0] grant_o,
  output logic             grant_valid_o,
  output logic             locked_o
);

  logic [IN_N-1:0]  arb_oh;
  logic [IN_N-1:0]  grant_oh;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd;
  logic             xfer;

  matrix_arb_prio #(.IN_N(IN_N)) u_prio (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .upd_i      (upd),
    .upd_idx_i  (upd_idx),
    .grant_oh_o (arb_oh)
  );

  assign arb_idx = IDX_W'(onehot2bin(16'(arb_oh)));

`ifdef MATRIX_ARB_LOCK_EN
  state_e           state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IN_N-1:0]  lock_oh;
  logic             tail;

  assign lock_oh = IN_N'(1) << lock_idx_q;

  // While locked only the owner can be granted; a dropped owner request is a bubble.
  always_comb begin
    grant_oh = arb_oh;
    if (state_q == ST_LOCKED) grant_oh = lock_oh & req_i;
  end

  assign xfer = (|grant_oh) & ready_i;
  // grant_oh is one-hot during a transfer, so this is last_i of the granted index.
  assign tail = |(grant_oh & last_i);

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    upd        = 1'b0;
    upd_idx    = arb_idx;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (tail) begin
            upd = 1'b1;
          end else begin
            state_d    = ST_LOCKED;
            lock_idx_d = arb_idx;
          end
        end
      end
      ST_LOCKED: begin
        upd_idx = lock_idx_q;
        if (xfer && tail) begin
          upd     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign locked_o = (state_q == ST_LOCKED);
`else
  logic unused_last;

  assign unused_last = ^last_i;
  assign grant_oh    = arb_oh;
  assign xfer        = (|grant_oh) & ready_i;
  assign upd         = xfer;
  assign upd_idx     = arb_idx;
  assign locked_o    = 1'b0;
`endif

  assign grant_oh_o    = grant_oh;
  assign grant_valid_o = |grant_oh;
  assign grant_o       = IDX_W'(onehot2bin(16'(grant_oh)));

endmodule

// File: tb/tb_matrix_arb_lock.sv
// Directed table-driven bench for matrix_arb_lock (IN_N=5), expectations for either build.
// Latency: inputs driven 1ns after the rising edge, outputs compared 4ns after it.
// Backpressure: ready_i is part of each vector.
`timescale 1ns/1ps
module tb_matrix_arb_lock;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] last = '0;
  logic         rdy = 1'b0;
  logic [N-1:0] g_oh;
  logic [2:0]   g_idx;
  logic         g_vld;
  logic         lk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_arb_lock #(.IN_N(N)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .last_i        (last),
    .ready_i       (rdy),
    .grant_oh_o    (g_oh),
    .grant_o       (g_idx),
    .grant_valid_o (g_vld),
    .locked_o      (lk)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         rdy;
    logic         vld;
    int           idx;
    logic         lk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] ls,
                     input logic rd, input logic v, input int ix, input logic l);
    vec_t e;
    e.rst = r; e.req = rq; e.last = ls; e.rdy = rd; e.vld = v; e.idx = ix; e.lk = l;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic check_outputs(input int row, input logic v, input int ix, input logic l);
    logic [N-1:0] e_oh;
    e_oh = v ? (N'(1) << ix) : '0;
    chk("grant_oh", row, 32'(g_oh), 32'(e_oh));
    chk("grant_idx", row, 32'(g_idx), v ? 32'(ix) : 32'd0);
    chk("grant_valid", row, 32'(g_vld), 32'(v));
    chk("locked", row, 32'(lk), 32'(l));
  endtask

  initial begin
    // reset state
    add(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
    // full request, single-flit packets: rotation 0..4
    for (int k = 0; k < N; k++) add(0, 5'b11111, 5'b11111, 1, 1, k, 0);
    // stalled downstream holds the grant and the matrix
    for (int k = 0; k < 3; k++) add(0, 5'b00110, 5'b11111, 0, 1, 1, 0);
    add(0, 5'b00110, 5'b11111, 1, 1, 1, 0);
    add(0, 5'b00110, 5'b11111, 0, 1, 2, 0);
    // order is now 0,2,3,4,1
    add(0, 5'b11010, 5'b11111, 0, 1, 3, 0);
    add(0, 5'b10010, 5'b11111, 0, 1, 4, 0);
    add(0, 5'b00011, 5'b11111, 0, 1, 0, 0);

    // lock scenario from reset priority
    add(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
`ifdef MATRIX_ARB_LOCK_EN
    add(0, 5'b01010, 5'b00000, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 5'b01010, 5'b00000, 1, 1, 1, 1);
    add(0, 5'b01010, 5'b00010, 1, 1, 1, 1);
    add(0, 5'b01010, 5'b11111, 0, 1, 3, 0);
`else
    add(0, 5'b01010, 5'b00000, 1, 1, 1, 0);
    add(0, 5'b01010, 5'b00000, 1, 1, 3, 0);
    add(0, 5'b01010, 5'b00000, 1, 1, 1, 0);
    add(0, 5'b01010, 5'b00000, 1, 1, 3, 0);
    add(0, 5'b01010, 5'b00010, 1, 1, 1, 0);
    add(0, 5'b01010, 5'b11111, 0, 1, 3, 0);
`endif

    // bubble while locked on requestor 2
    add(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
`ifdef MATRIX_ARB_LOCK_EN
    add(0, 5'b00100, 5'b00000, 1, 1, 2, 0);
    add(0, 5'b00001, 5'b00000, 1, 0, 0, 1);
    add(0, 5'b00001, 5'b00000, 1, 0, 0, 1);
    add(0, 5'b00101, 5'b00000, 1, 1, 2, 1);
    add(0, 5'b00101, 5'b00100, 1, 1, 2, 1);
    add(0, 5'b00101, 5'b11111, 0, 1, 0, 0);
`else
    add(0, 5'b00100, 5'b00000, 1, 1, 2, 0);
    add(0, 5'b00001, 5'b00000, 1, 1, 0, 0);
    add(0, 5'b00001, 5'b00000, 1, 1, 0, 0);
    add(0, 5'b00101, 5'b00000, 1, 1, 2, 0);
    add(0, 5'b00101, 5'b00100, 1, 1, 0, 0);
    add(0, 5'b00101, 5'b11111, 0, 1, 2, 0);
`endif

    // reset in the middle of a packet from requestor 4
    add(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
    add(0, 5'b10000, 5'b00000, 1, 1, 4, 0);
`ifdef MATRIX_ARB_LOCK_EN
    add(0, 5'b11111, 5'b00000, 1, 1, 4, 1);
`else
    add(0, 5'b11111, 5'b00000, 1, 1, 0, 0);
`endif
    add(1, 5'b11111, 5'b00000, 1, 1, 0, 0);
    add(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
    add(0, 5'b11111, 5'b11111, 0, 1, 0, 0);

    @(posedge clk);
    foreach (tbl[i]) begin
      #1;
      rst_n = ~tbl[i].rst;
      req   = tbl[i].req;
      last  = tbl[i].last;
      rdy   = tbl[i].rdy;
      #3;
      check_outputs(i, tbl[i].vld, tbl[i].idx, tbl[i].lk);
      @(posedge clk);
    end

    // two-requestor alternation with single-flit packets, starting from reset priority
    begin
      int exp_seq[3];
      exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0;
      for (int k = 0; k < 3; k++) begin
        #1;
        req  = 5'b00011;
        last = 5'b11111;
        rdy  = 1'b1;
        #3;
        check_outputs(100 + k, 1'b1, exp_seq[k], 1'b0);
        @(posedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
